// File: rtl/cons_dma_responder.sv
// cons_dma_responder
// Bus-side responder for the front-panel console DMA port. It takes the bus
// from the CPU (cpu_hold / cpu_hold_ack handshake), grants it to the console,
// runs one 16-bit Wishbone word transfer per console strobe, and returns the
// read data and ack. A transfer that the bus never acks is completed by a
// timeout and reported on the sticky dma_nxm flag.
//
// Ports:
//   clk_p, sys_init            clock, synchronous active-high reset
//   dma_req / dma_gnt          console bus request / grant
//   dma_adr_i, dma_dat_i,
//   dma_we_i, dma_stb_i        console transfer request (18-bit byte address)
//   dma_dat_o, dma_ack_o       console read data / transfer complete
//   dma_nxm                    sticky: last transfer timed out
//   cpu_hold / cpu_hold_ack    ask the CPU to release the bus / CPU released it
//   wb_*                       system Wishbone master port (22-bit address)
module cons_dma_responder #(
    parameter int unsigned TMO_CYCLES = 64,
    parameter int unsigned IOPAGE_MAP = 1
) (
    input  logic        clk_p,
    input  logic        sys_init,
    input  logic        dma_req,
    output logic        dma_gnt,
    input  logic [17:0] dma_adr_i,
    input  logic [15:0] dma_dat_i,
    output logic [15:0] dma_dat_o,
    input  logic        dma_stb_i,
    input  logic        dma_we_i,
    output logic        dma_ack_o,
    output logic        dma_nxm,
    output logic        cpu_hold,
    input  logic        cpu_hold_ack,
    output logic [21:0] wb_adr_o,
    output logic [15:0] wb_dat_o,
    input  logic [15:0] wb_dat_i,
    output logic        wb_we_o,
    output logic [1:0]  wb_sel_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_GRANT,
        S_XFER,
        S_RESP
    } state_t;

    // Counter starts one below the budget so the forced completion lands
    // exactly TMO_CYCLES edges after the strobe rises.
    localparam logic [7:0] TMO_LOAD = 8'(TMO_CYCLES - 1);

    state_t      state_q, state_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        dma_gnt_q, dma_gnt_d;
    logic        wb_cyc_q, wb_cyc_d;
    logic [21:0] adr_q, adr_d;
    logic [15:0] wdat_q, wdat_d;
    logic        we_q, we_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] dma_dat_q, dma_dat_d;
    logic        dma_ack_q, dma_ack_d;
    logic        nxm_q, nxm_d;

    logic [21:0] map_adr;
    logic        adr_unused;

    // Byte address bit 0 is meaningless for word transfers.
    assign adr_unused = dma_adr_i[0];

    // The top 8 KB of the 18-bit space is the I/O page; relocate it to the
    // top of the 22-bit space so devices decode the same way as CPU cycles.
    always_comb begin
        map_adr = {4'b0, dma_adr_i[17:1], 1'b0};
        if ((IOPAGE_MAP != 0) && (dma_adr_i[17:13] == 5'b11111))
            map_adr = {9'b111111111, dma_adr_i[12:1], 1'b0};
    end

    always_comb begin
        state_d    = state_q;
        cpu_hold_d = cpu_hold_q;
        dma_gnt_d  = dma_gnt_q;
        wb_cyc_d   = wb_cyc_q;
        adr_d      = adr_q;
        wdat_d     = wdat_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        dma_dat_d  = dma_dat_q;
        dma_ack_d  = dma_ack_q;
        nxm_d      = nxm_q;
        case (state_q)
            S_IDLE: begin
                if (dma_req) begin
                    cpu_hold_d = 1'b1;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                // Abort wins if the console gives up in the same cycle the CPU acks.
                if (!dma_req) begin
                    cpu_hold_d = 1'b0;
                    state_d    = S_IDLE;
                end else if (cpu_hold_ack) begin
                    dma_gnt_d = 1'b1;
                    state_d   = S_GRANT;
                end
            end
            S_GRANT: begin
                if (dma_stb_i) begin
                    adr_d    = map_adr;
                    wdat_d   = dma_we_i ? dma_dat_i : 16'o0;
                    we_d     = dma_we_i;
                    wb_cyc_d = 1'b1;
                    cnt_d    = TMO_LOAD;
                    state_d  = S_XFER;
                end else if (!dma_req) begin
                    dma_gnt_d  = 1'b0;
                    cpu_hold_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            S_XFER: begin
                if (wb_ack_i) begin
                    wb_cyc_d  = 1'b0;
                    if (!we_q)
                        dma_dat_d = wb_dat_i;
                    nxm_d     = 1'b0;
                    dma_ack_d = 1'b1;
                    state_d   = S_RESP;
                end else if (cnt_q == 8'd0) begin
                    wb_cyc_d  = 1'b0;
                    dma_dat_d = 16'o0;
                    nxm_d     = 1'b1;
                    dma_ack_d = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_RESP: begin
                // Ack is a level held until the console drops its strobe.
                if (!dma_stb_i) begin
                    dma_ack_d = 1'b0;
                    state_d   = S_GRANT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_p) begin
        if (sys_init) begin
            state_q    <= S_IDLE;
            cpu_hold_q <= 1'b0;
            dma_gnt_q  <= 1'b0;
            wb_cyc_q   <= 1'b0;
            adr_q      <= '0;
            wdat_q     <= '0;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            dma_dat_q  <= '0;
            dma_ack_q  <= 1'b0;
            nxm_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cpu_hold_q <= cpu_hold_d;
            dma_gnt_q  <= dma_gnt_d;
            wb_cyc_q   <= wb_cyc_d;
            adr_q      <= adr_d;
            wdat_q     <= wdat_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            dma_dat_q  <= dma_dat_d;
            dma_ack_q  <= dma_ack_d;
            nxm_q      <= nxm_d;
        end
    end

    assign dma_gnt   = dma_gnt_q;
    assign cpu_hold  = cpu_hold_q;
    assign dma_dat_o = dma_dat_q;
    assign dma_ack_o = dma_ack_q;
    assign dma_nxm   = nxm_q;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = wdat_q;
    assign wb_we_o   = we_q;
    assign wb_cyc_o  = wb_cyc_q;
    assign wb_stb_o  = wb_cyc_q;
    assign wb_sel_o  = wb_cyc_q ? 2'b11 : 2'b00;

endmodule

// File: tb/tb_cons_dma_responder.sv
module tb_cons_dma_responder;

    logic        clk_p = 1'b0;
    logic        sys_init = 1'b1;
    logic        dma_req = 1'b0;
    logic        dma_gnt;
    logic [17:0] dma_adr_i = '0;
    logic [15:0] dma_dat_i = '0;
    logic [15:0] dma_dat_o;
    logic        dma_stb_i = 1'b0;
    logic        dma_we_i = 1'b0;
    logic        dma_ack_o;
    logic        dma_nxm;
    logic        cpu_hold;
    logic        cpu_hold_ack = 1'b0;
    logic [21:0] wb_adr_o;
    logic [15:0] wb_dat_o;
    logic [15:0] wb_dat_i = '0;
    logic        wb_we_o;
    logic [1:0]  wb_sel_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i = 1'b0;

    int n_chk = 0;
    int n_pass = 0;

    cons_dma_responder #(.TMO_CYCLES(64), .IOPAGE_MAP(1)) dut (
        .clk_p(clk_p), .sys_init(sys_init), .dma_req(dma_req), .dma_gnt(dma_gnt),
        .dma_adr_i(dma_adr_i), .dma_dat_i(dma_dat_i), .dma_dat_o(dma_dat_o),
        .dma_stb_i(dma_stb_i), .dma_we_i(dma_we_i), .dma_ack_o(dma_ack_o),
        .dma_nxm(dma_nxm), .cpu_hold(cpu_hold), .cpu_hold_ack(cpu_hold_ack),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i)
    );

    always #5 clk_p = ~clk_p;

    // Untouched memory locations read back as a fixed function of the address.
    function automatic logic [15:0] dflt(input logic [21:0] a);
        return a[15:0] ^ 16'o052525;
    endfunction

    // Slave: acks slv_delay cycles after it first sees the strobe; 0 = never.
    int slv_delay = 1;
    int slv_n = 0;
    logic [15:0] mem [logic [21:0]];

    always @(posedge clk_p) begin
        if (wb_cyc_o && wb_stb_o && !wb_ack_i) begin
            slv_n = slv_n + 1;
            if (slv_delay > 0 && slv_n >= slv_delay) begin
                wb_ack_i <= 1'b1;
                if (wb_we_o) begin
                    mem[wb_adr_o] = wb_dat_o;
                    wb_dat_i <= 16'hDEAD;
                end else begin
                    wb_dat_i <= mem.exists(wb_adr_o) ? mem[wb_adr_o] : dflt(wb_adr_o);
                end
            end
        end else begin
            wb_ack_i <= 1'b0;
            slv_n = 0;
        end
    end

    // Reference model: address relocation from the map rule, memory contents,
    // and the console-visible data register.
    logic [15:0] mdl_mem [logic [21:0]];
    logic [15:0] mdl_dat = 16'o0;

    function automatic logic [21:0] mdl_map(input logic [17:0] a);
        int unsigned w;
        w = a;
        w = w - (w % 2);
        if (w >= 32'o760000) w = w + 32'o17000000;
        return 22'(w);
    endfunction

    function automatic logic [15:0] mdl_rd(input logic [21:0] ea);
        return mdl_mem.exists(ea) ? mdl_mem[ea] : dflt(ea);
    endfunction

    task automatic acquire(input int hdly, output logic ok);
        ok = 1'b0;
        @(negedge clk_p); dma_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_p); #1;
            if (cpu_hold) begin ok = 1'b1; break; end
        end
        if (!ok) return;
        repeat (hdly) @(negedge clk_p);
        @(negedge clk_p); cpu_hold_ack = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_p); #1;
            if (dma_gnt) begin ok = 1'b1; break; end
        end
    endtask

    task automatic release_bus(output logic g, output logic h);
        @(negedge clk_p); dma_req = 1'b0;
        @(posedge clk_p); #1;
        g = dma_gnt; h = cpu_hold;
        @(negedge clk_p); cpu_hold_ack = 1'b0;
    endtask

    // One console transfer. lat = edges from wb_stb_o rising to dma_ack_o
    // rising (-1 if no ack); rise = edge index at which wb_stb_o rose.
    // Console inputs are scrambled once the bus cycle starts; bus outputs are
    // captured on the last strobe cycle.
    task automatic xfer(input logic [17:0] a, input logic [15:0] d, input logic we,
                        input int dly, output int lat, output int rise,
                        output logic [21:0] adr, output logic wwe,
                        output logic [15:0] wdat, output logic [1:0] sel,
                        output logic [15:0] rdat, output logic nxm,
                        output logic cleared);
        lat = -1; rise = -1; adr = '0; wwe = 1'b0; wdat = '0; sel = '0;
        rdat = 16'hxxxx; nxm = 1'bx; cleared = 1'b0;
        slv_delay = dly;
        @(negedge clk_p);
        dma_adr_i = a; dma_dat_i = d; dma_we_i = we; dma_stb_i = 1'b1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(posedge clk_p); #1;
            if (wb_stb_o) begin
                if (rise < 0) rise = cyc;
                adr = wb_adr_o; wwe = wb_we_o; wdat = wb_dat_o; sel = wb_sel_o;
                dma_adr_i = ~a; dma_dat_i = ~d; dma_we_i = ~we;
            end
            if (dma_ack_o) begin
                lat = (rise < 0) ? -1 : cyc - rise;
                rdat = dma_dat_o; nxm = dma_nxm;
                break;
            end
        end
        @(negedge clk_p); dma_stb_i = 1'b0;
        @(posedge clk_p); #1;
        cleared = !dma_ack_o;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_p);
        sys_init = 1'b1;
        repeat (2) @(posedge clk_p);
        #1;
        n_chk++; if ({dma_gnt, cpu_hold, dma_ack_o, dma_nxm} !== 4'b0) $display("FAIL reset_ctl got %b exp 0000", {dma_gnt, cpu_hold, dma_ack_o, dma_nxm}); else n_pass++;
        n_chk++; if (dma_dat_o !== 16'o0) $display("FAIL reset_dat got %o exp 0", dma_dat_o); else n_pass++;
        n_chk++; if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o} !== 5'b0) $display("FAIL reset_wbctl got %b exp 00000", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}); else n_pass++;
        n_chk++; if ({wb_adr_o, wb_dat_o} !== 38'b0) $display("FAIL reset_wbbus got %h exp 0", {wb_adr_o, wb_dat_o}); else n_pass++;
        @(negedge clk_p); sys_init = 1'b0;
    endtask

    task automatic test_read();
        logic ok, cl, wwe, nxm, g, h; logic [21:0] adr; logic [15:0] wd, rd; logic [1:0] sel; int lat, rise;
        mem[22'o001000] = 16'o123456; mdl_mem[22'o001000] = 16'o123456;
        acquire(3, ok);
        n_chk++; if (ok !== 1'b1) $display("FAIL read_grant got %b exp 1", ok); else n_pass++;
        xfer(18'o001000, 16'o111111, 1'b0, 1, lat, rise, adr, wwe, wd, sel, rd, nxm, cl);
        n_chk++; if (adr !== 22'o001000) $display("FAIL read_adr got %o exp %o", adr, 22'o001000); else n_pass++;
        n_chk++; if ({wwe, sel, wd} !== {1'b0, 2'b11, 16'o0}) $display("FAIL read_wbctl got we=%b sel=%b dat=%o exp 0 11 0", wwe, sel, wd); else n_pass++;
        n_chk++; if (rise !== 1) $display("FAIL read_stb_latency got %0d exp 1", rise); else n_pass++;
        n_chk++; if (lat !== 2) $display("FAIL read_ack_latency got %0d exp 2", lat); else n_pass++;
        n_chk++; if (rd !== 16'o123456) $display("FAIL read_data got %o exp %o", rd, 16'o123456); else n_pass++;
        n_chk++; if (nxm !== 1'b0) $display("FAIL read_nxm got %b exp 0", nxm); else n_pass++;
        n_chk++; if (cl !== 1'b1) $display("FAIL read_ack_clear got %b exp 1", cl); else n_pass++;
        mdl_dat = 16'o123456;
        release_bus(g, h);
        n_chk++; if ({g, h} !== 2'b00) $display("FAIL read_release got gnt=%b hold=%b exp 0 0", g, h); else n_pass++;
    endtask

    task automatic test_write_iopage();
        logic ok, cl, wwe, nxm, g, h; logic [21:0] adr; logic [15:0] wd, rd; logic [1:0] sel; int lat, rise;
        acquire(1, ok);
        n_chk++; if (ok !== 1'b1) $display("FAIL wr_grant got %b exp 1", ok); else n_pass++;
        xfer(18'o777570, 16'o000777, 1'b1, 2, lat, rise, adr, wwe, wd, sel, rd, nxm, cl);
        n_chk++; if (adr !== 22'o17777570) $display("FAIL wr_adr got %o exp %o", adr, 22'o17777570); else n_pass++;
        n_chk++; if ({wwe, sel, wd} !== {1'b1, 2'b11, 16'o000777}) $display("FAIL wr_wbctl got we=%b sel=%b dat=%o exp 1 11 777", wwe, sel, wd); else n_pass++;
        n_chk++; if (lat !== 3) $display("FAIL wr_ack_latency got %0d exp 3", lat); else n_pass++;
        n_chk++; if (rd !== mdl_dat) $display("FAIL wr_dat_hold got %o exp %o", rd, mdl_dat); else n_pass++;
        n_chk++; if (wb_stb_o !== 1'b0) $display("FAIL wr_stb_drop got %b exp 0", wb_stb_o); else n_pass++;
        mdl_mem[22'o17777570] = 16'o000777;
        release_bus(g, h);
    endtask

    task automatic test_timeout();
        logic ok, cl, wwe, nxm, g, h; logic [21:0] adr; logic [15:0] wd, rd; logic [1:0] sel; int lat, rise;
        acquire(0, ok);
        n_chk++; if (ok !== 1'b1) $display("FAIL tmo_grant got %b exp 1", ok); else n_pass++;
        xfer(18'o002000, 16'o0, 1'b0, 0, lat, rise, adr, wwe, wd, sel, rd, nxm, cl);
        n_chk++; if (lat !== 64) $display("FAIL tmo_latency got %0d exp 64", lat); else n_pass++;
        n_chk++; if ({nxm, rd} !== {1'b1, 16'o0}) $display("FAIL tmo_result got nxm=%b dat=%o exp 1 0", nxm, rd); else n_pass++;
        xfer(18'o777570, 16'o0, 1'b0, 1, lat, rise, adr, wwe, wd, sel, rd, nxm, cl);
        n_chk++; if ({nxm, rd} !== {1'b0, 16'o000777}) $display("FAIL tmo_recover got nxm=%b dat=%o exp 0 777", nxm, rd); else n_pass++;
        mdl_dat = 16'o000777;
        release_bus(g, h);
    endtask

    task automatic test_abort_simul();
        logic ok, cl, wwe, nxm, g, h, seen_gnt; logic [21:0] adr; logic [15:0] wd, rd; logic [1:0] sel; int lat, rise;
        // (a) console gives up while still waiting for the CPU
        @(negedge clk_p); dma_req = 1'b1;
        @(posedge clk_p); #1;
        n_chk++; if (cpu_hold !== 1'b1) $display("FAIL abort_hold_rise got %b exp 1", cpu_hold); else n_pass++;
        @(negedge clk_p); dma_req = 1'b0;
        @(posedge clk_p); #1;
        n_chk++; if (cpu_hold !== 1'b0) $display("FAIL abort_hold_fall got %b exp 0", cpu_hold); else n_pass++;
        seen_gnt = dma_gnt;
        @(negedge clk_p); cpu_hold_ack = 1'b1;
        repeat (4) begin @(posedge clk_p); #1; seen_gnt = seen_gnt | dma_gnt | cpu_hold; end
        n_chk++; if (seen_gnt !== 1'b0) $display("FAIL abort_no_grant got %b exp 0", seen_gnt); else n_pass++;
        @(negedge clk_p); cpu_hold_ack = 1'b0;
        // (b) ack arrives in the cycle the timeout counter reaches zero
        acquire(2, ok);
        xfer(18'o003000, 16'o0, 1'b0, 0, lat, rise, adr, wwe, wd, sel, rd, nxm, cl);
        n_chk++; if (nxm !== 1'b1) $display("FAIL simul_pre_nxm got %b exp 1", nxm); else n_pass++;
        xfer(18'o004000, 16'o0, 1'b0, 63, lat, rise, adr, wwe, wd, sel, rd, nxm, cl);
        n_chk++; if (lat !== 64) $display("FAIL simul_latency got %0d exp 64", lat); else n_pass++;
        n_chk++; if ({nxm, rd} !== {1'b0, mdl_rd(22'o004000)}) $display("FAIL simul_result got nxm=%b dat=%o exp 0 %o", nxm, rd, mdl_rd(22'o004000)); else n_pass++;
        mdl_dat = mdl_rd(22'o004000);
        release_bus(g, h);
    endtask

    task automatic test_reset_mid();
        logic ok, cl, wwe, nxm, seen, got; logic [21:0] adr; logic [15:0] wd, rd; logic [1:0] sel; int lat, rise;
        acquire(0, ok);
        slv_delay = 0;
        @(negedge clk_p); dma_adr_i = 18'o005000; dma_we_i = 1'b0; dma_stb_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin @(posedge clk_p); #1; if (wb_stb_o) begin seen = 1'b1; break; end end
        n_chk++; if (seen !== 1'b1) $display("FAIL rstmid_stb got %b exp 1", seen); else n_pass++;
        @(negedge clk_p); sys_init = 1'b1;
        @(posedge clk_p); #1;
        n_chk++; if ({wb_cyc_o, wb_stb_o, dma_gnt, cpu_hold, dma_ack_o} !== 5'b0) $display("FAIL rstmid_drop got %b exp 00000", {wb_cyc_o, wb_stb_o, dma_gnt, cpu_hold, dma_ack_o}); else n_pass++;
        @(negedge clk_p); sys_init = 1'b0; dma_req = 1'b0; dma_stb_i = 1'b0; cpu_hold_ack = 1'b0;
        got = 1'b0;
        repeat (4) begin @(posedge clk_p); #1; got = got | dma_ack_o; end
        n_chk++; if (got !== 1'b0) $display("FAIL rstmid_no_ack got %b exp 0", got); else n_pass++;
        mdl_dat = 16'o0;
        acquire(1, ok);
        xfer(18'o005000, 16'o0, 1'b0, 1, lat, rise, adr, wwe, wd, sel, rd, nxm, cl);
        n_chk++; if ({ok, lat, rd} !== {1'b1, 32'd2, mdl_rd(22'o005000)}) $display("FAIL rstmid_recover got ok=%b lat=%0d dat=%o exp 1 2 %o", ok, lat, rd, mdl_rd(22'o005000)); else n_pass++;
        mdl_dat = mdl_rd(22'o005000);
    endtask

    task automatic test_random();
        logic cl, wwe, nxm, we, g, h; logic [21:0] adr, ea; logic [15:0] wd, rd, d; logic [1:0] sel;
        logic [17:0] a, bases [3]; int lat, rise, dly, elat;
        bases[0] = 18'o001000; bases[1] = 18'o757770; bases[2] = 18'o760000;
        for (int t = 0; t < 24; t++) begin
            a = bases[$urandom_range(0, 2)] + 18'(2 * $urandom_range(0, 7)) + 18'($urandom_range(0, 1));
            d = 16'($urandom);
            we = 1'($urandom_range(0, 1));
            dly = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
            ea = mdl_map(a);
            elat = (dly == 0) ? 64 : dly + 1;
            xfer(a, d, we, dly, lat, rise, adr, wwe, wd, sel, rd, nxm, cl);
            if (dly == 0) mdl_dat = 16'o0;
            else if (!we) mdl_dat = mdl_rd(ea);
            else mdl_mem[ea] = d;
            n_chk++;
            if ({adr, wwe, wd, sel} !== {ea, we, (we ? d : 16'o0), 2'b11} || lat !== elat
                || rd !== mdl_dat || nxm !== (dly == 0) || cl !== 1'b1)
                $display("FAIL rand_%0d got adr=%o we=%b wd=%o lat=%0d rd=%o nxm=%b clr=%b exp adr=%o we=%b wd=%o lat=%0d rd=%o nxm=%b clr=1",
                         t, adr, wwe, wd, lat, rd, nxm, cl, ea, we, (we ? d : 16'o0), elat, mdl_dat, (dly == 0));
            else n_pass++;
        end
        release_bus(g, h);
        n_chk++; if ({g, h} !== 2'b00) $display("FAIL rand_release got gnt=%b hold=%b exp 0 0", g, h); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_iopage();
        test_timeout();
        test_abort_simul();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
